// File: rtl/pc_unit.sv
// Fetch PC register with next-PC selection, delay-slot FSM and stall.
// Optional macro PC_ALIGN_CHECK_EN: trap misaligned jump-register targets.
module pc_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
    parameter bit          DELAY_SLOT   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             exception,
    input  logic             redirect_valid,
    input  logic [1:0]       redirect_type,
    input  logic [WIDTH-1:0] base_pc,
    input  logic [15:0]      branch_offset,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_target,
`ifdef PC_ALIGN_CHECK_EN
    output logic             pc_misalign,
`endif
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             delay_pending,
    output logic             redirect_ignored
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] FOUR   = WIDTH'(32'd4);

    logic [0:0]       state;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pend_q;
    logic             ign_q;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] base4;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] target;
    logic             is_br;
    logic             is_j;

    assign seq_pc = pc_q + FOUR;
    assign base4  = base_pc + FOUR;
    assign br_off = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign is_br  = (redirect_type == 2'b00);
    assign is_j   = (redirect_type == 2'b01);

    always_comb begin
        target = jr_target;
        unique case (1'b1)
            is_br:   target = base4 + br_off;
            is_j:    target = {base4[WIDTH-1:28], jump_index, 2'b00};
            default: target = jr_target;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q;
    logic jr_bad;

    assign jr_bad      = !is_br && !is_j && (jr_target[1:0] != 2'b00);
    assign pc_misalign = mis_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= RST_PC;
            pend_q <= '0;
            state  <= IDLE;
            ign_q  <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            mis_q  <= 1'b0;
`endif
        end else begin
            ign_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            mis_q <= 1'b0;
`endif
            if (exception) begin
                pc_q   <= EXC_PC;
                pend_q <= '0;
                state  <= IDLE;
            end else if (stall) begin
                pc_q   <= pc_q;
            end else if (state == PENDING) begin
                // a redirect arriving in the delay slot is dropped
                pc_q  <= pend_q;
                state <= IDLE;
                ign_q <= redirect_valid;
`ifdef PC_ALIGN_CHECK_EN
            end else if (redirect_valid && jr_bad) begin
                pc_q  <= EXC_PC;
                state <= IDLE;
                mis_q <= 1'b1;
`endif
            end else if (redirect_valid) begin
                if (DELAY_SLOT) begin
                    pc_q   <= seq_pc;
                    pend_q <= target;
                    state  <= PENDING;
                end else begin
                    pc_q <= target;
                end
            end else begin
                pc_q <= seq_pc;
            end
        end
    end

    assign pc_out           = pc_q;
    assign pc_plus4         = seq_pc;
    assign delay_pending    = (state == PENDING);
    assign redirect_ignored = ign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit, delay-slot and no-delay builds.
// Checks reset, redirects, stall, exception, drop, wrap and alignment.
module tb_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        exception;
    logic        redirect_valid;
    logic [1:0]  redirect_type;
    logic [31:0] base_pc;
    logic [15:0] branch_offset;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        delay_pending;
    logic        redirect_ignored;
    logic [31:0] nd_pc;
    logic [31:0] nd_pc4;
    logic        nd_dp;
    logic        nd_ign;
`ifdef PC_ALIGN_CHECK_EN
    logic        pc_misalign;
    logic        nd_mis;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit #(.WIDTH(32), .DELAY_SLOT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .exception(exception), .redirect_valid(redirect_valid),
        .redirect_type(redirect_type), .base_pc(base_pc),
        .branch_offset(branch_offset), .jump_index(jump_index),
        .jr_target(jr_target),
`ifdef PC_ALIGN_CHECK_EN
        .pc_misalign(pc_misalign),
`endif
        .pc_out(pc_out), .pc_plus4(pc_plus4),
        .delay_pending(delay_pending), .redirect_ignored(redirect_ignored)
    );

    pc_unit #(.WIDTH(32), .DELAY_SLOT(1'b0)) dut_nd (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .exception(exception), .redirect_valid(redirect_valid),
        .redirect_type(redirect_type), .base_pc(base_pc),
        .branch_offset(branch_offset), .jump_index(jump_index),
        .jr_target(jr_target),
`ifdef PC_ALIGN_CHECK_EN
        .pc_misalign(nd_mis),
`endif
        .pc_out(nd_pc), .pc_plus4(nd_pc4),
        .delay_pending(nd_dp), .redirect_ignored(nd_ign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // jump-register hop: leaves the delay-slot unit at addr, FSM idle
    task automatic go_to(input logic [31:0] addr);
        redirect_type  = 2'b10;
        jr_target      = addr;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (pc_out !== 32'h0 || delay_pending !== 1'b0 || redirect_ignored !== 1'b0) begin
            $display("FAIL reset_async pc=%h dp=%b ign=%b want 0/0/0", pc_out, delay_pending, redirect_ignored);
            n_fail++;
        end
        #1 reset_n = 1'b1;
        step();
        n_checks++;
        if (pc_out !== 32'h4 || nd_pc !== 32'h4) begin
            $display("FAIL reset_rel1 pc=%h nd=%h want 4", pc_out, nd_pc);
            n_fail++;
        end
        step();
        n_checks++;
        if (pc_out !== 32'h8 || pc_plus4 !== 32'hC) begin
            $display("FAIL reset_rel2 pc=%h p4=%h want 8/c", pc_out, pc_plus4);
            n_fail++;
        end
    endtask

    task automatic test_branch();
        go_to(32'h100);
        n_checks++;
        if (pc_out !== 32'h100) begin
            $display("FAIL goto pc=%h want 100", pc_out);
            n_fail++;
        end
        base_pc        = 32'h100;
        branch_offset  = 16'h0010;
        redirect_type  = 2'b00;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (pc_out !== 32'h104 || delay_pending !== 1'b1) begin
            $display("FAIL br_slot pc=%h dp=%b want 104/1", pc_out, delay_pending);
            n_fail++;
        end
        step();
        n_checks++;
        if (pc_out !== 32'h144 || delay_pending !== 1'b0) begin
            $display("FAIL br_take pc=%h dp=%b want 144/0", pc_out, delay_pending);
            n_fail++;
        end
        step();
        n_checks++;
        if (pc_out !== 32'h148) begin
            $display("FAIL br_next pc=%h want 148", pc_out);
            n_fail++;
        end
        go_to(32'h200);
        base_pc        = 32'h200;
        branch_offset  = 16'hFFFE;
        redirect_type  = 2'b00;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        step();
        n_checks++;
        if (pc_out !== 32'h1FC) begin
            $display("FAIL br_neg pc=%h want 1fc", pc_out);
            n_fail++;
        end
    endtask

    task automatic test_jump_stall();
        go_to(32'h1000_0000);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        base_pc        = 32'h1000_0000;
        jump_index     = 26'h40;
        redirect_type  = 2'b01;
        step();
        n_checks++;
        if (pc_out !== 32'h1000_0000 || delay_pending !== 1'b0) begin
            $display("FAIL stall_idle pc=%h dp=%b want 10000000/0", pc_out, delay_pending);
            n_fail++;
        end
        stall = 1'b0;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (pc_out !== 32'h1000_0004 || delay_pending !== 1'b1) begin
            $display("FAIL j_stall pc=%h dp=%b want 10000004/1", pc_out, delay_pending);
            n_fail++;
        end
        stall = 1'b0;
        step();
        n_checks++;
        if (pc_out !== 32'h1000_0100 || delay_pending !== 1'b0) begin
            $display("FAIL j_take pc=%h dp=%b want 10000100/0", pc_out, delay_pending);
            n_fail++;
        end
    endtask

    task automatic test_exception();
        go_to(32'h400);
        base_pc        = 32'h400;
        branch_offset  = 16'h0008;
        redirect_type  = 2'b00;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b1;
        exception      = 1'b1;
        step();
        n_checks++;
        if (pc_out !== 32'h8000_0180 || delay_pending !== 1'b0) begin
            $display("FAIL exc pc=%h dp=%b want 80000180/0", pc_out, delay_pending);
            n_fail++;
        end
        stall     = 1'b0;
        exception = 1'b0;
        step();
        n_checks++;
        if (pc_out !== 32'h8000_0184) begin
            $display("FAIL exc_after pc=%h want 80000184", pc_out);
            n_fail++;
        end
    endtask

    task automatic test_drop_wrap();
        go_to(32'h300);
        redirect_type  = 2'b10;
        jr_target      = 32'h500;
        redirect_valid = 1'b1;
        step();
        jr_target = 32'h700;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (pc_out !== 32'h500 || redirect_ignored !== 1'b1 || delay_pending !== 1'b0) begin
            $display("FAIL drop pc=%h ign=%b dp=%b want 500/1/0", pc_out, redirect_ignored, delay_pending);
            n_fail++;
        end
        step();
        n_checks++;
        if (pc_out !== 32'h504 || redirect_ignored !== 1'b0) begin
            $display("FAIL drop_next pc=%h ign=%b want 504/0", pc_out, redirect_ignored);
            n_fail++;
        end
        go_to(32'hFFFF_FFFC);
        n_checks++;
        if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            $display("FAIL wrap_pre pc=%h p4=%h want fffffffc/0", pc_out, pc_plus4);
            n_fail++;
        end
        step();
        n_checks++;
        if (pc_out !== 32'h0) begin
            $display("FAIL wrap pc=%h want 0", pc_out);
            n_fail++;
        end
    endtask

    task automatic test_no_delay();
        base_pc        = 32'h100;
        branch_offset  = 16'h0010;
        redirect_type  = 2'b00;
        redirect_valid = 1'b1;
        step();
        n_checks++;
        if (nd_pc !== 32'h144 || nd_dp !== 1'b0) begin
            $display("FAIL nd_br pc=%h dp=%b want 144/0", nd_pc, nd_dp);
            n_fail++;
        end
        redirect_valid = 1'b0;
        step();
        base_pc        = 32'h2345_6780;
        jump_index     = 26'h3FF_FFFF;
        redirect_type  = 2'b01;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (nd_pc !== 32'h2FFF_FFFC) begin
            $display("FAIL nd_j pc=%h want 2ffffffc", nd_pc);
            n_fail++;
        end
        step();
        n_checks++;
        if (nd_pc !== 32'h3000_0000 || nd_ign !== 1'b0) begin
            $display("FAIL nd_seq pc=%h ign=%b want 30000000/0", nd_pc, nd_ign);
            n_fail++;
        end
    endtask

`ifdef PC_ALIGN_CHECK_EN
    task automatic test_align();
        go_to(32'h600);
        redirect_type  = 2'b10;
        jr_target      = 32'h0000_2002;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (pc_out !== 32'h8000_0180 || pc_misalign !== 1'b1 || delay_pending !== 1'b0) begin
            $display("FAIL align pc=%h mis=%b dp=%b want 80000180/1/0", pc_out, pc_misalign, delay_pending);
            n_fail++;
        end
        step();
        n_checks++;
        if (pc_out !== 32'h8000_0184 || pc_misalign !== 1'b0) begin
            $display("FAIL align_next pc=%h mis=%b want 80000184/0", pc_out, pc_misalign);
            n_fail++;
        end
    endtask
`endif

    initial begin
        reset_n        = 1'b0;
        stall          = 1'b0;
        exception      = 1'b0;
        redirect_valid = 1'b0;
        redirect_type  = 2'b00;
        base_pc        = '0;
        branch_offset  = '0;
        jump_index     = '0;
        jr_target      = '0;
        test_reset();
        test_branch();
        test_jump_stall();
        test_exception();
        test_drop_wrap();
        test_no_delay();
`ifdef PC_ALIGN_CHECK_EN
        test_align();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
